// File: rtl/risc_mem_pkg.sv
// Shared MEM-stage types: address/data widths
// and the buffered-store entry layout.
package risc_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_if.sv
// MEM-stage request bus and data-memory bus
// seen by the posted-store buffer.
interface mem_store_buffer_if;
  import risc_mem_pkg::*;

  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_stall;
  logic [DATA_W-1:0] ld_data;

  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_we,
    input  req_addr, req_wdata,
    output req_stall, ld_data,
    output mem_access_addr,
    output mem_write_data,
    output mem_write_en, mem_read,
    input  mem_read_data
  );

  modport master (
    output req_valid, req_we,
    output req_addr, req_wdata,
    input  req_stall, ld_data,
    input  mem_access_addr,
    input  mem_write_data,
    input  mem_write_en, mem_read,
    output mem_read_data
  );

endinterface

// File: rtl/sb_fifo.sv
// Store-buffer entry storage: in-order FIFO
// with per-slot valid bits and address match.
module sb_fifo
  import risc_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  sb_entry_t         push_entry,
  input  logic              pop,
  input  logic [ADDR_W-1:0] match_addr,
  output sb_entry_t         head_entry,
  output logic [PW-1:0]     head,
  output logic [CW-1:0]     count,
  output logic [DEPTH-1:0]  match_vec,
  output sb_entry_t         entries [DEPTH]
);

  sb_entry_t        mem_q [DEPTH];
  sb_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for pointers, count and slots.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      mem_d[tail_q]   = push_entry;
      tail_d = tail_q + PW'(1);
    end
    count_d = count_q + CW'(push)
            - CW'(pop);
  end

  // State registers; reset discards entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q   <= '{default: '0};
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Parallel full-width address compare.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid_q[i] &&
        (mem_q[i].addr == match_addr);
    end
  end

  assign head_entry = mem_q[head_q];
  assign head       = head_q;
  assign count      = count_q;
  assign entries    = mem_q;

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-store buffer between MEM stage and
// data memory; loads win the port and forward.
module mem_store_buffer
  import risc_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  mem_store_buffer_if.slave bus,
  input  logic flush,
  output logic flush_done,
  output logic [$clog2(DEPTH+1)-1:0] sb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push, pop;
  sb_entry_t        push_entry;
  sb_entry_t        head_entry;
  logic [PW-1:0]    head;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] match_vec;
  sb_entry_t        entries [DEPTH];

  logic             nonempty, full;
  logic             flush_mode;
  logic             ld_go, st_full;
  logic             st_go, idle_drain;
  logic             fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PW-1:0]    idx;

  sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .match_addr (bus.req_addr),
    .head_entry (head_entry),
    .head       (head),
    .count      (count),
    .match_vec  (match_vec),
    .entries    (entries)
  );

  assign nonempty   = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign flush_mode = flush & nonempty;

  assign ld_go = ~flush_mode &
    bus.req_valid & ~bus.req_we;
  assign st_full = ~flush_mode &
    bus.req_valid & bus.req_we & full;
  assign st_go = ~flush_mode &
    bus.req_valid & bus.req_we & ~full;
  assign idle_drain = ~flush_mode &
    ~bus.req_valid & nonempty;

  assign push_entry.addr = bus.req_addr;
  assign push_entry.data = bus.req_wdata;

  // Youngest match wins: walk oldest to newest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (match_vec[idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

  // Memory port arbitration.
  always_comb begin
    push                = 1'b0;
    pop                 = 1'b0;
    bus.req_stall       = 1'b0;
    bus.ld_data         = '0;
    bus.mem_read        = 1'b0;
    bus.mem_write_en    = 1'b0;
    bus.mem_access_addr = '0;
    bus.mem_write_data  = '0;
    unique case (1'b1)
      flush_mode: begin
        bus.req_stall = bus.req_valid;
        pop = 1'b1;
      end
      ld_go: begin
        bus.mem_read        = 1'b1;
        bus.mem_access_addr = bus.req_addr;
        bus.ld_data = fwd_hit ? fwd_data
                    : bus.mem_read_data;
      end
      st_full: begin
        bus.req_stall = 1'b1;
        pop = 1'b1;
      end
      st_go: begin
        push = 1'b1;
      end
      idle_drain: begin
        pop = 1'b1;
      end
      default: ;
    endcase
    if (pop) begin
      bus.mem_write_en    = 1'b1;
      bus.mem_access_addr = head_entry.addr;
      bus.mem_write_data  = head_entry.data;
    end
  end

  assign flush_done = flush & ~nonempty;
  assign sb_count   = count;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer with a
// behavioural data memory on the bus.
module tb_mem_store_buffer;
  import risc_mem_pkg::*;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       flush_done;
  logic [2:0] sb_count;
  int         checks;
  int         errors;

  logic [DATA_W-1:0] mem [0:65535];

  mem_store_buffer_if bus ();

  mem_store_buffer #(
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .flush      (flush),
    .flush_done (flush_done),
    .sb_count   (sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_access_addr];

  always @(posedge clk) begin
    if (bus.mem_write_en)
      mem[bus.mem_access_addr] <= bus.mem_write_data;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic we,
                       input logic [15:0] a,
                       input logic [15:0] d);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 65536; i++)
      mem[i] = 16'(i) ^ 16'hA5A5;
    rst   = 1'b0;
    flush = 1'b0;
    drive(0, 0, 16'h0, 16'h0);

    // 1: reset
    repeat (3) step();
    @(negedge clk);
    chk("rst_count", 32'(sb_count), 0);
    chk("rst_fdone", 32'(flush_done), 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rel_count", 32'(sb_count), 0);
    chk("rel_stall", 32'(bus.req_stall), 0);
    chk("rel_we", 32'(bus.mem_write_en), 0);
    chk("rel_rd", 32'(bus.mem_read), 0);
    chk("rel_ld", 32'(bus.ld_data), 0);
    chk("rel_addr", 32'(bus.mem_access_addr), 0);

    // 2: forward youngest store
    step();
    drive(1, 1, 16'h0010, 16'hBEEF);
    @(negedge clk);
    chk("s2_stall0", 32'(bus.req_stall), 0);
    step();
    drive(1, 1, 16'h0010, 16'h1234);
    @(negedge clk);
    chk("s2_cnt1", 32'(sb_count), 1);
    step();
    drive(1, 0, 16'h0010, 16'h0);
    @(negedge clk);
    chk("s2_cnt2", 32'(sb_count), 2);
    chk("s2_ld", 32'(bus.ld_data), 32'h1234);
    chk("s2_rd", 32'(bus.mem_read), 1);
    chk("s2_we", 32'(bus.mem_write_en), 0);
    chk("s2_addr", 32'(bus.mem_access_addr),
        32'h0010);
    step();
    drive(0, 0, 16'h0, 16'h0);
    @(negedge clk);
    chk("s2_d1", 32'(bus.mem_write_data),
        32'hBEEF);
    step();
    @(negedge clk);
    chk("s2_d2", 32'(bus.mem_write_data),
        32'h1234);
    step();
    @(negedge clk);
    chk("s2_empty", 32'(sb_count), 0);
    chk("s2_mem", 32'(mem[16'h0010]), 32'h1234);

    // 3: fill, stall on full, accept next
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1, 1, 16'h0100 + 16'(i),
            16'hA000 + 16'(i));
      @(negedge clk);
      chk("s3_cnt", 32'(sb_count), 32'(i));
      chk("s3_nostall", 32'(bus.req_stall), 0);
    end
    step();
    drive(1, 1, 16'h0104, 16'hA004);
    @(negedge clk);
    chk("s3_full", 32'(sb_count), 4);
    chk("s3_stall", 32'(bus.req_stall), 1);
    chk("s3_we", 32'(bus.mem_write_en), 1);
    chk("s3_waddr", 32'(bus.mem_access_addr),
        32'h0100);
    step();
    @(negedge clk);
    chk("s3_acc", 32'(bus.req_stall), 0);
    chk("s3_cnt3", 32'(sb_count), 3);
    step();
    drive(0, 0, 16'h0, 16'h0);
    @(negedge clk);
    chk("s3_cnt4", 32'(sb_count), 4);
    for (int i = 1; i < 5; i++) begin
      chk("s3_dwe", 32'(bus.mem_write_en), 1);
      chk("s3_daddr", 32'(bus.mem_access_addr),
          32'h0100 + 32'(i));
      step();
      @(negedge clk);
    end
    chk("s3_empty", 32'(sb_count), 0);
    chk("s3_mem", 32'(mem[16'h0104]), 32'hA004);

    // 4: in-order drain of three stores
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1, 1, 16'h0200 + 16'(i),
            16'hB000 + 16'(i));
    end
    step();
    drive(0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s4_cnt", 32'(sb_count), 32'(3 - i));
      chk("s4_we", 32'(bus.mem_write_en), 1);
      chk("s4_addr", 32'(bus.mem_access_addr),
          32'h0200 + 32'(i));
      chk("s4_data", 32'(bus.mem_write_data),
          32'hB000 + 32'(i));
      step();
    end
    @(negedge clk);
    chk("s4_cnt0", 32'(sb_count), 0);
    chk("s4_we0", 32'(bus.mem_write_en), 0);

    // 5: flush with a pending load
    step();
    drive(1, 1, 16'h0300, 16'h5555);
    step();
    drive(1, 1, 16'h0301, 16'h6666);
    step();
    drive(1, 0, 16'h0300, 16'h0);
    flush = 1'b1;
    @(negedge clk);
    chk("s5_st1", 32'(bus.req_stall), 1);
    chk("s5_fd1", 32'(flush_done), 0);
    chk("s5_a1", 32'(bus.mem_access_addr),
        32'h0300);
    chk("s5_ld0", 32'(bus.ld_data), 0);
    step();
    @(negedge clk);
    chk("s5_st2", 32'(bus.req_stall), 1);
    chk("s5_a2", 32'(bus.mem_access_addr),
        32'h0301);
    step();
    @(negedge clk);
    chk("s5_fd3", 32'(flush_done), 1);
    chk("s5_st3", 32'(bus.req_stall), 0);
    chk("s5_rd", 32'(bus.mem_read), 1);
    chk("s5_ld", 32'(bus.ld_data), 32'h5555);
    step();
    flush = 1'b0;
    drive(0, 0, 16'h0, 16'h0);

    // 6: async reset mid-drain
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1, 1, 16'h0400 + 16'(i),
            16'h7770 + 16'(i));
    end
    step();
    drive(0, 0, 16'h0, 16'h0);
    #2;
    chk("s6_we1", 32'(bus.mem_write_en), 1);
    chk("s6_cnt3", 32'(sb_count), 3);
    rst = 1'b0;
    #1;
    chk("s6_we0", 32'(bus.mem_write_en), 0);
    chk("s6_cnt0", 32'(sb_count), 0);
    step();
    rst = 1'b1;
    drive(1, 0, 16'h0400, 16'h0);
    @(negedge clk);
    chk("s6_rd", 32'(bus.mem_read), 1);
    chk("s6_ld", 32'(bus.ld_data), 32'hA1A5);
    step();
    drive(0, 0, 16'h0, 16'h0);
    step();

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
